// File: rtl/spi_device_if.sv
// SPI pin and control-side signals of the SPI slave front end.
// The slave modport is the device view; the master modport drives the pins and control inputs.
interface spi_device_if;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       spi_cs;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic [7:0] spi_tx_data;
    logic       spi_tx_strobe;

    modport slave (
        input  sck, cs_n, mosi, spi_tx_data, spi_tx_strobe,
        output miso, miso_oe, spi_cs, spi_rx_data, spi_rx_strobe
    );

    modport master (
        output sck, cs_n, mosi, spi_tx_data, spi_tx_strobe,
        input  miso, miso_oe, spi_cs, spi_rx_data, spi_rx_strobe
    );
endinterface

// File: rtl/spi_device.sv
// SPI slave front end, mode 0, MSB first. Pins are synchronised into clk,
// bytes are deserialised to spi_rx_data and serialised from spi_tx_data onto MISO.
module spi_device #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic         clk,
    input  logic         reset_n,
    spi_device_if.slave  bus
);
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_prev;
    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, selected;

    logic [2:0] bit_count;
    logic [7:0] rx_shift, rx_next, tx_shift, hold, rx_data;
    logic       pending, rx_strobe, miso_r, miso_oe_r, spi_cs_r;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign selected = ~cs_s;
    assign rx_next  = {rx_shift[6:0], mosi_s};

    // Idle chain values: SCK low, chip deselected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_prev  <= sck_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_count <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= FILL_BYTE;
            hold      <= 8'h00;
            pending   <= 1'b0;
            rx_data   <= 8'h00;
            rx_strobe <= 1'b0;
            miso_r    <= FILL_BYTE[7];
            miso_oe_r <= 1'b0;
            spi_cs_r  <= 1'b1;
        end else begin
            rx_strobe <= 1'b0;
            spi_cs_r  <= cs_s;
            miso_oe_r <= selected;
            miso_r    <= tx_shift[7];
            // Held cleared while deselected: covers mid-byte deselect and
            // beats a coincident 8th rise, so a partial byte never strobes.
            if (!selected) begin
                bit_count <= 3'd0;
                rx_shift  <= 8'h00;
                tx_shift  <= FILL_BYTE;
                pending   <= 1'b0;
            end else if (sck_rise) begin
                rx_shift  <= rx_next;
                bit_count <= bit_count + 3'd1;
                if (bit_count == 3'd7) begin
                    rx_data   <= rx_next;
                    rx_strobe <= 1'b1;
                    tx_shift  <= bus.spi_tx_strobe ? bus.spi_tx_data :
                                 pending           ? hold : FILL_BYTE;
                    pending   <= 1'b0;
                end else if (bus.spi_tx_strobe) begin
                    hold    <= bus.spi_tx_data;
                    pending <= 1'b1;
                end
            end else begin
                // No shift on the fall right after a reload keeps the new MSB presented.
                if (sck_fall && bit_count != 3'd0)
                    tx_shift <= {tx_shift[6:0], 1'b0};
                if (bus.spi_tx_strobe) begin
                    if (bit_count == 3'd0) begin
                        tx_shift <= bus.spi_tx_data;
                    end else begin
                        hold    <= bus.spi_tx_data;
                        pending <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.miso          = miso_r;
    assign bus.miso_oe       = miso_oe_r;
    assign bus.spi_cs        = spi_cs_r;
    assign bus.spi_rx_data   = rx_data;
    assign bus.spi_rx_strobe = rx_strobe;
endmodule

// File: tb/tb_spi_device.sv
// Bench for spi_device: a transaction-level SPI master with a byte-level model of
// what MISO must carry and when spi_rx_strobe must fire; one per-cycle compare process.
module tb_spi_device;
    localparam logic [7:0] FILL = 8'h00;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi_device_if bus ();

    spi_device #(.SYNC_STAGES(2), .FILL_BYTE(FILL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Byte-level model: byte to shift out now, hold byte and its pending flag,
    // last received byte, and strobes due at given cycle numbers.
    logic [7:0] m_cur = FILL;
    logic [7:0] m_hold = 8'h00;
    bit         m_pend = 1'b0;
    logic [7:0] last_rx = 8'h00;
    int         due_q[$];
    logic [7:0] dat_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // cs history: spi_cs after edge n must equal the cs_n pin seen at edge n-2.
    initial begin
        bit h0, h1, h2;
        h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            h2 = h1; h1 = h0; h0 = reset_n ? bus.cs_n : 1'b1;
            #1;
            if (!reset_n) begin
                chk("rst_strobe", {31'd0, bus.spi_rx_strobe}, 32'd0);
                chk("rst_spi_cs", {31'd0, bus.spi_cs}, 32'd1);
                chk("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
                chk("rst_rx_data", {24'd0, bus.spi_rx_data}, 32'd0);
            end else begin
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    chk("rx_strobe", {31'd0, bus.spi_rx_strobe}, 32'd1);
                    last_rx = dat_q[0];
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                end else begin
                    chk("rx_strobe_idle", {31'd0, bus.spi_rx_strobe}, 32'd0);
                end
                chk("rx_data", {24'd0, bus.spi_rx_data}, {24'd0, last_rx});
                chk("spi_cs", {31'd0, bus.spi_cs}, {31'd0, h2});
                chk("miso_oe", {31'd0, bus.miso_oe}, {31'd0, ~h2});
            end
        end
    end

    task automatic frame_start();
        bus.cs_n = 1'b0;
        m_cur = FILL; m_pend = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        bus.cs_n = 1'b1;
        m_cur = FILL; m_pend = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // One byte (or nbits<8 partial). wp1/wp2: bit position of a tx write in the low
    // phase before that rise (-1 none). ew: tx write landing in the completion cycle.
    task automatic xfer(input logic [7:0] mo, input int wp1, input logic [7:0] wd1,
                        input int wp2, input logic [7:0] wd2, input bit ew,
                        input logic [7:0] ed, input int nbits, output logic [7:0] got);
        logic [7:0] d;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k == 4 && (wp1 == i || wp2 == i)) begin
                    d = (wp2 == i) ? wd2 : wd1;
                    bus.spi_tx_strobe = 1'b1;
                    bus.spi_tx_data = d;
                    if (i == 0) m_cur = d;
                    else begin m_hold = d; m_pend = 1'b1; end
                end
                if (k == 5) bus.spi_tx_strobe = 1'b0;
            end
            got[7-i] = bus.miso;
            bus.sck = 1'b1;
            if (i == 7) begin
                due_q.push_back(cyc + 3);
                dat_q.push_back(mo);
            end
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k == 2 && ew && i == 7) begin
                    bus.spi_tx_strobe = 1'b1;
                    bus.spi_tx_data = ed;
                end
                if (k == 3) bus.spi_tx_strobe = 1'b0;
            end
            bus.sck = 1'b0;
        end
        if (nbits == 8) begin
            chk("miso_byte", {24'd0, got}, {24'd0, m_cur});
            m_cur = ew ? ed : (m_pend ? m_hold : FILL);
            m_pend = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] g;
        int nb, wp1, wp2, nbits;
        bit ew;
        reset_n = 1'b0;
        bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        bus.spi_tx_strobe = 1'b0; bus.spi_tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("init_miso", {31'd0, bus.miso}, {31'd0, FILL[7]});
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Two back-to-back bytes in one frame.
        frame_start();
        xfer(8'h05, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        xfer(8'hA5, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        frame_end();
        chk("c2_rx_data", {24'd0, bus.spi_rx_data}, 32'h A5);

        // Write before first SCK goes out immediately; next byte is fill.
        frame_start();
        xfer(8'h11, 0, 8'h3C, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c3_miso_3c", {24'd0, g}, 32'h3C);
        xfer(8'h22, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c3_miso_fill", {24'd0, g}, 32'h00);
        frame_end();

        // Mid-byte writes land on the next byte; last write wins.
        frame_start();
        xfer(8'h33, 3, 8'h81, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c4_byte0", {24'd0, g}, 32'h00);
        xfer(8'h44, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c4_byte1", {24'd0, g}, 32'h81);
        xfer(8'h55, 3, 8'h81, 5, 8'h7E, 1'b0, 8'h00, 8, g);
        xfer(8'h66, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c4_overwrite", {24'd0, g}, 32'h7E);
        frame_end();

        // Deselect after 5 bits, then a clean byte.
        frame_start();
        xfer(8'hF0, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 5, g);
        frame_end();
        frame_start();
        xfer(8'hC3, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        frame_end();
        chk("c5_rx_data", {24'd0, bus.spi_rx_data}, 32'hC3);

        // Write in the completion cycle beats a pending hold byte.
        frame_start();
        xfer(8'h77, 3, 8'h11, -1, 8'h00, 1'b1, 8'h99, 8, g);
        xfer(8'h88, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c6_next", {24'd0, g}, 32'h99);
        xfer(8'h99, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        chk("c6_after", {24'd0, g}, 32'h00);
        frame_end();

        // Reset in the middle of a byte.
        frame_start();
        xfer(8'hFF, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 4, g);
        reset_n = 1'b0;
        last_rx = 8'h00; due_q.delete(); dat_q.delete();
        m_cur = FILL; m_pend = 1'b0;
        #1;
        chk("c1_spi_cs", {31'd0, bus.spi_cs}, 32'd1);
        chk("c1_rx_data", {24'd0, bus.spi_rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        xfer(8'h5A, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8, g);
        frame_end();
        chk("c1_after_rx", {24'd0, bus.spi_rx_data}, 32'h5A);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            nb = int'($urandom_range(1, 4));
            frame_start();
            for (int b = 0; b < nb; b++) begin
                wp1 = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7));
                wp2 = (wp1 >= 0 && wp1 < 7 && $urandom_range(0, 2) == 0) ?
                      int'($urandom_range(wp1 + 1, 7)) : -1;
                ew = ($urandom_range(0, 4) == 0);
                nbits = (b == nb - 1 && $urandom_range(0, 3) == 0) ?
                        int'($urandom_range(1, 7)) : 8;
                xfer(8'($urandom), wp1, 8'($urandom), wp2, 8'($urandom),
                     ew, 8'($urandom), nbits, g);
            end
            frame_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
